// File: rtl/store_buffer_pkg.sv
// Shared configuration and bundle types for the post-execute store buffer.
package store_buffer_pkg;

    localparam int ADDR_WIDTH        = 32;
    localparam int SIZE_WIDTH        = 3;
    localparam int BUS_DATA_WIDTH    = 32;
    localparam int REG_DATA_WIDTH    = 32;
    localparam int ROB_ID_WIDTH      = 7;
    localparam int COMMIT_WIDTH      = 4;
    localparam int STORE_BUFFER_SIZE = 16;

    localparam int PTR_WIDTH = $clog2(STORE_BUFFER_SIZE);
    localparam int BUS_BYTES = BUS_DATA_WIDTH / 8;
    localparam int OFF_WIDTH = $clog2(BUS_BYTES);

    typedef struct packed {
        logic                                     enable;
        logic                                     next_handle_rob_id_valid;
        logic [ROB_ID_WIDTH-1:0]                  next_handle_rob_id;
        logic                                     has_exception;
        logic [ADDR_WIDTH-1:0]                    exception_pc;
        logic                                     flush;
        logic [COMMIT_WIDTH-1:0][ROB_ID_WIDTH-1:0] committed_rob_id;
        logic [COMMIT_WIDTH-1:0]                  committed_rob_id_valid;
        logic                                     jump_enable;
        logic                                     jump;
        logic [ADDR_WIDTH-1:0]                    next_pc;
    } commit_feedback_pack_t;

    typedef struct packed {
        logic [ROB_ID_WIDTH-1:0]   rob_id;
        logic [ADDR_WIDTH-1:0]     addr;
        logic [SIZE_WIDTH-1:0]     size;
        logic [BUS_DATA_WIDTH-1:0] data;
        logic                      committed;
    } entry_t;

    function automatic logic [BUS_DATA_WIDTH-1:0] size_mask(
        input logic [SIZE_WIDTH-1:0] size
    );
        case (size)
            3'd1:    size_mask = BUS_DATA_WIDTH'(8'hff);
            3'd2:    size_mask = BUS_DATA_WIDTH'(16'hffff);
            default: size_mask = '1;
        endcase
    endfunction

endpackage

// File: rtl/store_buffer_forward.sv
// Byte merge of registered forwarded store bytes over returning bus data.
module store_buffer_forward
    import store_buffer_pkg::*;
(
    input  logic [BUS_DATA_WIDTH-1:0] fwd_data,
    input  logic [BUS_BYTES-1:0]      fwd_mask,
    input  logic [BUS_DATA_WIDTH-1:0] bus_data,
    output logic [BUS_DATA_WIDTH-1:0] merged
);

    always_comb begin
        merged = bus_data;
        for (int b = 0; b < BUS_BYTES; b++) begin
            if (fwd_mask[b]) begin
                merged[b*8 +: 8] = fwd_data[b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// In-order store queue: holds stores until commit, drains oldest first,
// and forwards younger buffered bytes into load returns.
module store_buffer
    import store_buffer_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ADDR_WIDTH-1:0]       issue_stbuf_read_addr,
    input  logic [SIZE_WIDTH-1:0]       issue_stbuf_read_size,
    input  logic                        issue_stbuf_rd,
    output logic [BUS_DATA_WIDTH-1:0]   stbuf_exlsu_bus_data,
    output logic [BUS_DATA_WIDTH-1:0]   stbuf_exlsu_bus_data_feedback,
    output logic                        stbuf_exlsu_bus_ready,
    input  logic [ROB_ID_WIDTH-1:0]     exlsu_stbuf_rob_id,
    input  logic [ADDR_WIDTH-1:0]       exlsu_stbuf_write_addr,
    input  logic [SIZE_WIDTH-1:0]       exlsu_stbuf_write_size,
    input  logic [BUS_DATA_WIDTH-1:0]   exlsu_stbuf_write_data,
    input  logic                        exlsu_stbuf_push,
    output logic                        stbuf_exlsu_full,
    output logic                        stbuf_all_empty,
    output logic [ADDR_WIDTH-1:0]       stbuf_bus_read_addr,
    output logic [SIZE_WIDTH-1:0]       stbuf_bus_read_size,
    output logic                        stbuf_bus_read_req,
    output logic [ADDR_WIDTH-1:0]       stbuf_bus_write_addr,
    output logic [SIZE_WIDTH-1:0]       stbuf_bus_write_size,
    output logic [REG_DATA_WIDTH-1:0]   stbuf_bus_data,
    output logic                        stbuf_bus_write_req,
    input  logic [REG_DATA_WIDTH-1:0]   bus_stbuf_data,
    input  logic                        bus_stbuf_read_ack,
    input  logic                        bus_stbuf_write_ack,
    input  commit_feedback_pack_t       commit_feedback_pack
);

    entry_t                  entries [STORE_BUFFER_SIZE];
    logic [PTR_WIDTH-1:0]    rptr;
    logic [PTR_WIDTH-1:0]    wptr;
    logic                    rptr_wrap;
    logic                    wptr_wrap;
    logic [PTR_WIDTH:0]      occ;
    logic [PTR_WIDTH:0]      keep;
    logic                    empty;
    logic                    full;
    logic                    push_fire;
    logic                    write_fire;
    logic                    flush_now;
    logic [STORE_BUFFER_SIZE-1:0] commit_hit;
    logic [BUS_DATA_WIDTH-1:0] fwd_data;
    logic [BUS_DATA_WIDTH-1:0] fwd_data_q;
    logic [BUS_BYTES-1:0]    fwd_mask;
    logic [BUS_BYTES-1:0]    fwd_mask_q;
    entry_t                  head;
    logic                    unused_ok;

    assign occ   = {wptr_wrap, wptr} - {rptr_wrap, rptr};
    assign empty = (rptr == wptr) && (rptr_wrap == wptr_wrap);
    assign full  = (rptr == wptr) && (rptr_wrap != wptr_wrap);

    assign stbuf_exlsu_full = full;
    assign stbuf_all_empty  = empty;

    assign push_fire  = exlsu_stbuf_push && !full;
    assign flush_now  = commit_feedback_pack.enable && commit_feedback_pack.flush;
    assign write_fire = stbuf_bus_write_req && bus_stbuf_write_ack;

    assign head                 = entries[rptr];
    assign stbuf_bus_write_req  = !empty && head.committed;
    assign stbuf_bus_write_addr = head.addr;
    assign stbuf_bus_write_size = head.size;
    assign stbuf_bus_data       = REG_DATA_WIDTH'(head.data & size_mask(head.size));

    assign stbuf_bus_read_req  = issue_stbuf_rd;
    assign stbuf_bus_read_addr = issue_stbuf_read_addr;
    assign stbuf_bus_read_size = issue_stbuf_read_size;

    assign stbuf_exlsu_bus_ready = bus_stbuf_read_ack;
    assign stbuf_exlsu_bus_data  = BUS_DATA_WIDTH'(bus_stbuf_data);

    assign unused_ok = ^{commit_feedback_pack.next_handle_rob_id_valid,
                         commit_feedback_pack.next_handle_rob_id,
                         commit_feedback_pack.has_exception,
                         commit_feedback_pack.exception_pc,
                         commit_feedback_pack.jump_enable,
                         commit_feedback_pack.jump,
                         commit_feedback_pack.next_pc};

    always_comb begin
        commit_hit = '0;
        for (int i = 0; i < STORE_BUFFER_SIZE; i++) begin : hit_scan
            logic [PTR_WIDTH-1:0] offs;
            offs = PTR_WIDTH'(i) - rptr;
            if (commit_feedback_pack.enable && ({1'b0, offs} < occ)) begin
                for (int c = 0; c < COMMIT_WIDTH; c++) begin
                    if (commit_feedback_pack.committed_rob_id_valid[c] &&
                        commit_feedback_pack.committed_rob_id[c] == entries[i].rob_id) begin
                        commit_hit[i] = 1'b1;
                    end
                end
            end
        end
    end

    // Commits retire in order, so the committed entries form a run from the head.
    always_comb begin
        logic                 run;
        logic [PTR_WIDTH-1:0] idx;
        keep = '0;
        run  = 1'b1;
        idx  = '0;
        for (int j = 0; j < STORE_BUFFER_SIZE; j++) begin
            idx = rptr + PTR_WIDTH'(j);
            if (run && ((PTR_WIDTH+1)'(j) < occ) &&
                (entries[idx].committed || commit_hit[idx])) begin
                keep = keep + 1'b1;
            end else begin
                run = 1'b0;
            end
        end
    end

    // Scan oldest to newest so the youngest covering store wins each byte.
    always_comb begin
        logic [PTR_WIDTH-1:0]  idx;
        logic [ADDR_WIDTH:0]   byte_addr;
        logic [ADDR_WIDTH:0]   lo;
        logic [ADDR_WIDTH:0]   hi;
        logic [OFF_WIDTH-1:0]  off;
        fwd_data  = '0;
        fwd_mask  = '0;
        idx       = '0;
        byte_addr = '0;
        lo        = '0;
        hi        = '0;
        off       = '0;
        for (int k = 0; k < BUS_BYTES; k++) begin
            for (int j = 0; j < STORE_BUFFER_SIZE; j++) begin
                idx       = rptr + PTR_WIDTH'(j);
                byte_addr = {1'b0, issue_stbuf_read_addr} + (ADDR_WIDTH+1)'(k);
                lo        = {1'b0, entries[idx].addr};
                hi        = lo + (ADDR_WIDTH+1)'(entries[idx].size);
                off       = OFF_WIDTH'(byte_addr - lo);
                if ((SIZE_WIDTH'(k) < issue_stbuf_read_size) &&
                    ((PTR_WIDTH+1)'(j) < occ) &&
                    byte_addr >= lo && byte_addr < hi) begin
                    fwd_data[k*8 +: 8] = entries[idx].data[int'(off)*8 +: 8];
                    fwd_mask[k]        = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rptr       <= '0;
            wptr       <= '0;
            rptr_wrap  <= 1'b0;
            wptr_wrap  <= 1'b0;
            fwd_data_q <= '0;
            fwd_mask_q <= '0;
            for (int i = 0; i < STORE_BUFFER_SIZE; i++) begin
                entries[i].committed <= 1'b0;
            end
        end else begin
            for (int i = 0; i < STORE_BUFFER_SIZE; i++) begin
                if (commit_hit[i]) begin
                    entries[i].committed <= 1'b1;
                end
            end
            if (write_fire) begin
                {rptr_wrap, rptr} <= {rptr_wrap, rptr} + 1'b1;
            end
            if (flush_now) begin
                {wptr_wrap, wptr} <= {rptr_wrap, rptr} + keep;
            end else if (push_fire) begin
                entries[wptr].rob_id    <= exlsu_stbuf_rob_id;
                entries[wptr].addr      <= exlsu_stbuf_write_addr;
                entries[wptr].size      <= exlsu_stbuf_write_size;
                entries[wptr].data      <= exlsu_stbuf_write_data;
                entries[wptr].committed <= 1'b0;
                {wptr_wrap, wptr}       <= {wptr_wrap, wptr} + 1'b1;
            end
            if (issue_stbuf_rd) begin
                fwd_data_q <= fwd_data;
                fwd_mask_q <= fwd_mask;
            end
        end
    end

    store_buffer_forward u_forward (
        .fwd_data (fwd_data_q),
        .fwd_mask (fwd_mask_q),
        .bus_data (BUS_DATA_WIDTH'(bus_stbuf_data)),
        .merged   (stbuf_exlsu_bus_data_feedback)
    );

endmodule

// File: tb/tb_store_buffer.sv
// Scenario bench for store_buffer: write-drain scoreboard plus load-return queue.
module tb_store_buffer;
    import store_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] rd_addr = '0;
    logic [2:0]  rd_size = '0;
    logic        rd = 1'b0;
    logic [31:0] ld_data;
    logic [31:0] ld_fb;
    logic        ld_ready;
    logic [6:0]  st_rob = '0;
    logic [31:0] st_addr = '0;
    logic [2:0]  st_size = '0;
    logic [31:0] st_data = '0;
    logic        push = 1'b0;
    logic        full;
    logic        all_empty;
    logic [31:0] bus_rd_addr;
    logic [2:0]  bus_rd_size;
    logic        bus_rd_req;
    logic [31:0] bus_wr_addr;
    logic [2:0]  bus_wr_size;
    logic [31:0] bus_wr_data;
    logic        bus_wr_req;
    logic [31:0] bus_data_in = '0;
    logic        rd_ack = 1'b0;
    logic        wr_ack = 1'b0;
    commit_feedback_pack_t cfp = '0;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] data;
    } wr_t;
    typedef struct {
        logic [31:0] raw;
        logic [31:0] fb;
    } ld_t;
    wr_t exp_wr[$];
    ld_t exp_ld[$];

    store_buffer dut (
        .clk                           (clk),
        .rst                           (rst),
        .issue_stbuf_read_addr         (rd_addr),
        .issue_stbuf_read_size         (rd_size),
        .issue_stbuf_rd                (rd),
        .stbuf_exlsu_bus_data          (ld_data),
        .stbuf_exlsu_bus_data_feedback (ld_fb),
        .stbuf_exlsu_bus_ready         (ld_ready),
        .exlsu_stbuf_rob_id            (st_rob),
        .exlsu_stbuf_write_addr        (st_addr),
        .exlsu_stbuf_write_size        (st_size),
        .exlsu_stbuf_write_data        (st_data),
        .exlsu_stbuf_push              (push),
        .stbuf_exlsu_full              (full),
        .stbuf_all_empty               (all_empty),
        .stbuf_bus_read_addr           (bus_rd_addr),
        .stbuf_bus_read_size           (bus_rd_size),
        .stbuf_bus_read_req            (bus_rd_req),
        .stbuf_bus_write_addr          (bus_wr_addr),
        .stbuf_bus_write_size          (bus_wr_size),
        .stbuf_bus_data                (bus_wr_data),
        .stbuf_bus_write_req           (bus_wr_req),
        .bus_stbuf_data                (bus_data_in),
        .bus_stbuf_read_ack            (rd_ack),
        .bus_stbuf_write_ack           (wr_ack),
        .commit_feedback_pack          (cfp)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic push_store(input logic [6:0] rob, input logic [31:0] a,
                              input logic [2:0] s, input logic [31:0] d);
        st_rob  = rob;
        st_addr = a;
        st_size = s;
        st_data = d;
        push    = 1'b1;
        step();
        push    = 1'b0;
    endtask

    task automatic commit_rob(input logic [6:0] rob);
        cfp = '0;
        cfp.enable = 1'b1;
        cfp.committed_rob_id[0] = rob;
        cfp.committed_rob_id_valid[0] = 1'b1;
        step();
        cfp = '0;
    endtask

    task automatic do_flush();
        cfp = '0;
        cfp.enable = 1'b1;
        cfp.flush  = 1'b1;
        step();
        cfp = '0;
    endtask

    task automatic expect_write(input logic [31:0] a, input logic [2:0] s,
                                input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.size = s;
        e.data = d;
        exp_wr.push_back(e);
    endtask

    // Consumer side of the write scoreboard: ack each request a cycle late.
    task automatic drain_writes(input int n);
        int   got;
        int   cycles;
        wr_t  e;
        got = 0;
        cycles = 0;
        while (got < n && cycles < 50) begin
            if (bus_wr_req) begin
                compared++;
                if (exp_wr.size() == 0) begin
                    mismatched++;
                    $display("FAIL wr_unexpected: addr=%h with empty scoreboard", bus_wr_addr);
                end else begin
                    e = exp_wr.pop_front();
                    if (bus_wr_addr !== e.addr || bus_wr_size !== e.size ||
                        bus_wr_data !== e.data) begin
                        mismatched++;
                        $display("FAIL wr_beat: got %h/%0d/%h want %h/%0d/%h",
                                 bus_wr_addr, bus_wr_size, bus_wr_data,
                                 e.addr, e.size, e.data);
                    end
                end
                step();
                compared++;
                if (bus_wr_req !== 1'b1 || bus_wr_addr !== e.addr) begin
                    mismatched++;
                    $display("FAIL wr_hold: req=%b addr=%h want 1/%h",
                             bus_wr_req, bus_wr_addr, e.addr);
                end
                wr_ack = 1'b1;
                step();
                wr_ack = 1'b0;
                got++;
            end else begin
                step();
                cycles++;
            end
        end
        compared++;
        if (got !== n) begin
            mismatched++;
            $display("FAIL wr_timeout: got %0d beats want %0d", got, n);
        end
    endtask

    task automatic load(input logic [31:0] a, input logic [2:0] s,
                        input logic [31:0] bus, input logic [31:0] fb);
        ld_t e;
        e.raw = bus;
        e.fb  = fb;
        exp_ld.push_back(e);
        rd_addr = a;
        rd_size = s;
        rd = 1'b1;
        #1;
        compared++;
        if (bus_rd_req !== 1'b1 || bus_rd_addr !== a || bus_rd_size !== s) begin
            mismatched++;
            $display("FAIL rd_pass: req=%b addr=%h size=%0d want 1/%h/%0d",
                     bus_rd_req, bus_rd_addr, bus_rd_size, a, s);
        end
        step();
        rd = 1'b0;
        bus_data_in = bus;
        rd_ack = 1'b1;
        #1;
        e = exp_ld.pop_front();
        compared++;
        if (ld_ready !== 1'b1 || ld_data !== e.raw || ld_fb !== e.fb) begin
            mismatched++;
            $display("FAIL ld_return: rdy=%b raw=%h fb=%h want 1/%h/%h",
                     ld_ready, ld_data, ld_fb, e.raw, e.fb);
        end
        step();
        rd_ack = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        compared++;
        if (dut.rptr !== 4'd0 || dut.wptr !== 4'd0 ||
            dut.rptr_wrap !== 1'b0 || dut.wptr_wrap !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_ptrs: rptr=%0d wptr=%0d", dut.rptr, dut.wptr);
        end
        compared++;
        if (all_empty !== 1'b1 || full !== 1'b0 || bus_wr_req !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_outs: empty=%b full=%b req=%b want 1/0/0",
                     all_empty, full, bus_wr_req);
        end
    endtask

    task automatic test_commit_drain();
        push_store(7'd3, 32'h100, 3'd4, 32'h11223344);
        compared++;
        if (bus_wr_req !== 1'b0 || all_empty !== 1'b0) begin
            mismatched++;
            $display("FAIL uncommitted_hold: req=%b empty=%b want 0/0", bus_wr_req, all_empty);
        end
        expect_write(32'h100, 3'd4, 32'h11223344);
        commit_rob(7'd3);
        drain_writes(1);
        compared++;
        if (dut.rptr !== 4'd1 || all_empty !== 1'b1) begin
            mismatched++;
            $display("FAIL drain_done: rptr=%0d empty=%b want 1/1", dut.rptr, all_empty);
        end
    endtask

    task automatic test_forward();
        push_store(7'd5, 32'h201, 3'd1, 32'h000000ab);
        load(32'h200, 3'd4, 32'h00000000, 32'h0000ab00);
        do_flush();
        compared++;
        if (all_empty !== 1'b1) begin
            mismatched++;
            $display("FAIL fwd_flush_empty: empty=%b want 1", all_empty);
        end
        push_store(7'd6, 32'h300, 3'd2, 32'h00001111);
        push_store(7'd7, 32'h301, 3'd1, 32'h00000022);
        load(32'h300, 3'd4, 32'haabbccdd, 32'haabb2211);
        do_flush();
        bus_data_in = 32'hffffffff;
        rd_ack = 1'b1;
        #1;
        compared++;
        if (ld_fb !== 32'hffff2211) begin
            mismatched++;
            $display("FAIL fwd_held: fb=%h want ffff2211", ld_fb);
        end
        step();
        rd_ack = 1'b0;
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            push_store(7'(i + 1), 32'h1000 + 32'(i * 4), 3'd4, 32'(i));
        end
        compared++;
        if (full !== 1'b1 || all_empty !== 1'b0 ||
            dut.wptr !== 4'd0 || dut.wptr_wrap !== 1'b1) begin
            mismatched++;
            $display("FAIL full_set: full=%b empty=%b wptr=%0d wrap=%b want 1/0/0/1",
                     full, all_empty, dut.wptr, dut.wptr_wrap);
        end
        push_store(7'd77, 32'h2000, 3'd4, 32'hdeadbeef);
        compared++;
        if (full !== 1'b1 || dut.wptr !== 4'd0 || dut.entries[0].rob_id !== 7'd1) begin
            mismatched++;
            $display("FAIL full_ignore: full=%b wptr=%0d rob0=%0d want 1/0/1",
                     full, dut.wptr, dut.entries[0].rob_id);
        end
        do_flush();
        compared++;
        if (all_empty !== 1'b1 || full !== 1'b0) begin
            mismatched++;
            $display("FAIL full_flush: empty=%b full=%b want 1/0", all_empty, full);
        end
    endtask

    task automatic test_flush();
        int extra;
        do_reset();
        push_store(7'd1, 32'h400, 3'd4, 32'haaaa0001);
        push_store(7'd2, 32'h404, 3'd4, 32'haaaa0002);
        push_store(7'd3, 32'h408, 3'd4, 32'haaaa0003);
        expect_write(32'h400, 3'd4, 32'haaaa0001);
        commit_rob(7'd1);
        do_flush();
        compared++;
        if (dut.wptr !== 4'd1 || dut.rptr !== 4'd0) begin
            mismatched++;
            $display("FAIL flush_wptr: wptr=%0d rptr=%0d want 1/0", dut.wptr, dut.rptr);
        end
        drain_writes(1);
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus_wr_req) extra++;
            step();
        end
        compared++;
        if (extra !== 0 || all_empty !== 1'b1) begin
            mismatched++;
            $display("FAIL flush_discard: extra_req_cycles=%0d empty=%b want 0/1",
                     extra, all_empty);
        end
    endtask

    task automatic test_size_mask();
        push_store(7'd9, 32'h10, 3'd2, 32'hdeadbeef);
        push_store(7'd10, 32'h20, 3'd1, 32'hcafef00d);
        expect_write(32'h10, 3'd2, 32'h0000beef);
        commit_rob(7'd9);
        expect_write(32'h20, 3'd1, 32'h0000000d);
        commit_rob(7'd10);
        drain_writes(2);
    endtask

    task automatic test_back_to_back();
        push_store(7'd20, 32'h500, 3'd4, 32'h01010101);
        push_store(7'd21, 32'h504, 3'd4, 32'h02020202);
        push_store(7'd22, 32'h508, 3'd4, 32'h03030303);
        expect_write(32'h500, 3'd4, 32'h01010101);
        expect_write(32'h504, 3'd4, 32'h02020202);
        expect_write(32'h508, 3'd4, 32'h03030303);
        cfp = '0;
        cfp.enable = 1'b1;
        cfp.committed_rob_id[0] = 7'd20;
        cfp.committed_rob_id[1] = 7'd21;
        cfp.committed_rob_id[2] = 7'd22;
        cfp.committed_rob_id_valid = 4'b0111;
        step();
        cfp = '0;
        drain_writes(3);
        compared++;
        if (all_empty !== 1'b1 || exp_wr.size() !== 0) begin
            mismatched++;
            $display("FAIL b2b_end: empty=%b left=%0d want 1/0", all_empty, exp_wr.size());
        end
    endtask

    initial begin
        test_reset();
        test_commit_drain();
        test_forward();
        test_full();
        test_flush();
        test_size_mask();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
